// File: rtl/jtag_burst_bus_master.sv
// Burst bus master for the JTAG debug path: queues write data, issues single/burst bus transactions, collects read data.
// Latency: command accept -> request 2 cycles min; grant -> begin 1 cycle; N write words -> N cycles + 1 end cycle.
// Backpressure: cmd_ready only while idle; wdata_ready/rdata_valid follow FIFO fill; busyIN stalls write words on the bus.

module jtag_burst_bus_master_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [8:0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [8:0]    count_q;
    logic          push_ok;
    logic          pop_ok;

    // Push into a full FIFO and pop from an empty one are silently dropped.
    assign push_ok = push_i && (count_q != 9'(DEPTH));
    assign pop_ok  = pop_i && (count_q != 9'd0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 9'd1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 9'd1;
            end
        end
    end
endmodule

module jtag_burst_bus_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic              cmd_read_n_write,
    input  logic [3:0]        cmd_byte_enable,
    input  logic [7:0]        cmd_burst_size,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [ADDR_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              status_done,
    output logic              status_error,
    output logic              request,
    input  logic              granted,
    output logic [ADDR_W-1:0] address_dataOUT,
    output logic [3:0]        byte_enableOUT,
    output logic [7:0]        burst_sizeOUT,
    output logic              read_n_writeOUT,
    output logic              begin_transactionOUT,
    output logic              end_transactionOUT,
    output logic              data_validOUT,
    output logic              busyOUT,
    input  logic [ADDR_W-1:0] address_dataIN,
    input  logic              end_transactionIN,
    input  logic              data_validIN,
    input  logic              busyIN,
    input  logic              errorIN
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RES,
        S_REQ,
        S_BEGIN,
        S_WDATA,
        S_RDATA,
        S_END,
        S_DISCARD
    } state_t;

    state_t            state_q;
    logic              alive_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rnw_q;
    logic [3:0]        be_q;
    logic [7:0]        bsize_q;
    logic [8:0]        cnt_q;
    logic              abort_q;
    logic              done_q;
    logic              err_q;

    logic [8:0]        burst_len;
    logic [8:0]        last_idx;
    logic [8:0]        wf_count;
    logic [8:0]        rf_count;
    logic [8:0]        rf_free;
    logic [ADDR_W-1:0] wf_head;
    logic              wf_push;
    logic              wf_pop;
    logic              rf_push;
    logic [8:0]        rd_words_d;

    assign burst_len  = {1'b0, bsize_q} + 9'd1;
    assign last_idx   = {1'b0, bsize_q};
    assign rf_free    = 9'(FIFO_DEPTH) - rf_count;

    // Host-side FIFO handshakes; alive_q keeps the ready flags low while in reset.
    assign wf_push     = wdata_valid && wdata_ready;
    assign wdata_ready = alive_q && (wf_count != 9'(FIFO_DEPTH));
    assign rdata_valid = (rf_count != 9'd0);
    assign cmd_ready   = alive_q && (state_q == S_IDLE);

    // Write words leave the FIFO when the slave takes them, or one per cycle while realigning after an abort.
    assign wf_pop = ((state_q == S_WDATA) && !errorIN && !busyIN) || (state_q == S_DISCARD);
    // Read words beyond the requested burst length are dropped.
    assign rf_push    = (state_q == S_RDATA) && data_validIN && (cnt_q < burst_len);
    assign rd_words_d = cnt_q + {8'd0, rf_push};

    jtag_burst_bus_master_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W)) u_wfifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wf_push),
        .din_i   (wdata),
        .pop_i   (wf_pop),
        .dout_o  (wf_head),
        .count_o (wf_count)
    );

    jtag_burst_bus_master_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W)) u_rfifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rf_push),
        .din_i   (address_dataIN),
        .pop_i   (rdata_ready),
        .dout_o  (rdata),
        .count_o (rf_count)
    );

    // Transaction sequencer: command latch, resource wait, arbitration, data phase, end and abort cleanup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            alive_q <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            bsize_q <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_address;
                        rnw_q   <= cmd_read_n_write;
                        be_q    <= cmd_byte_enable;
                        bsize_q <= cmd_burst_size;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        // burst_size+1 > depth is the same as burst_size >= depth
                        if ({1'b0, cmd_burst_size} >= 9'(FIFO_DEPTH)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_RES;
                        end
                    end
                end
                S_WAIT_RES: begin
                    // Whole burst must fit before requesting the bus, so the data phase never starves or overflows.
                    if (rnw_q ? (rf_free >= burst_len) : (wf_count >= burst_len)) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (granted) begin
                        state_q <= S_BEGIN;
                    end
                end
                S_BEGIN: begin
                    if (errorIN) begin
                        abort_q <= 1'b1;
                        state_q <= S_END;
                    end else begin
                        state_q <= rnw_q ? S_RDATA : S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (errorIN) begin
                        abort_q <= 1'b1;
                        state_q <= S_END;
                    end else if (!busyIN) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (cnt_q == last_idx) begin
                            state_q <= S_END;
                        end
                    end
                end
                S_RDATA: begin
                    cnt_q <= rd_words_d;
                    if (errorIN) begin
                        abort_q <= 1'b1;
                        state_q <= S_END;
                    end else if (end_transactionIN) begin
                        state_q <= S_IDLE;
                        if (rd_words_d == burst_len) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    // An aborted write still owns unsent words in the FIFO; flush them so the next burst starts aligned.
                    if (abort_q && !rnw_q && (cnt_q != burst_len)) begin
                        state_q <= S_DISCARD;
                    end else begin
                        state_q <= S_IDLE;
                        done_q  <= !abort_q;
                        err_q   <= abort_q;
                    end
                end
                S_DISCARD: begin
                    cnt_q <= cnt_q + 9'd1;
                    if (cnt_q == last_idx) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the state register only and held at zero whenever not driving (wired-OR bus).
    always_comb begin
        request              = 1'b0;
        address_dataOUT      = '0;
        byte_enableOUT       = '0;
        burst_sizeOUT        = '0;
        read_n_writeOUT      = 1'b0;
        begin_transactionOUT = 1'b0;
        end_transactionOUT   = 1'b0;
        data_validOUT        = 1'b0;
        unique case (state_q)
            S_REQ:   request = 1'b1;
            S_BEGIN: begin
                request              = 1'b1;
                begin_transactionOUT = 1'b1;
                address_dataOUT      = addr_q;
                byte_enableOUT       = be_q;
                burst_sizeOUT        = bsize_q;
                read_n_writeOUT      = rnw_q;
            end
            S_WDATA: begin
                request         = 1'b1;
                data_validOUT   = 1'b1;
                address_dataOUT = wf_head;
            end
            S_RDATA: request = 1'b1;
            S_END: begin
                request            = 1'b1;
                end_transactionOUT = 1'b1;
            end
            default: request = 1'b0;
        endcase
    end

    assign busyOUT      = 1'b0;
    assign status_done  = done_q;
    assign status_error = err_q;
endmodule
